// File: rtl/watch_set_ctrl.sv
// Watch time-set controller: shadow edit of {Y,M,D,h,m,s} with one-cycle load strobe.
// Define WATCH_SET_TIMEOUT_EN to abort edit mode after TIMEOUT_SEC idle seconds.
module watch_set_ctrl #(
    parameter int unsigned TIMEOUT_SEC = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk1sec,
    input  logic        btn_mode,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_cancel,
    input  logic [7:0]  cur_year,
    input  logic [7:0]  cur_month,
    input  logic [7:0]  cur_day,
    input  logic [7:0]  cur_hour,
    input  logic [7:0]  cur_minute,
    input  logic [7:0]  cur_second,
    output logic        set_time,
    output logic [47:0] bin_time,
    output logic        editing,
    output logic [2:0]  edit_field
);

    typedef enum logic [2:0] {
        RUN        = 3'd0,
        EDIT_YEAR  = 3'd1,
        EDIT_MONTH = 3'd2,
        EDIT_DAY   = 3'd3,
        EDIT_HOUR  = 3'd4,
        EDIT_MIN   = 3'd5,
        EDIT_SEC   = 3'd6,
        COMMIT     = 3'd7
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] yr_q, yr_d;
    logic [7:0] mo_q, mo_d;
    logic [7:0] dy_q, dy_d;
    logic [7:0] hr_q, hr_d;
    logic [7:0] mi_q, mi_d;
    logic [7:0] se_q, se_d;

    logic       step_en;
    logic       accept;
    logic [7:0] mo_step;
    logic [7:0] mo_san;

    function automatic logic [7:0] max_day(input logic [7:0] m);
        case (m)
            8'd2:                         return 8'd28;
            8'd4, 8'd6, 8'd9, 8'd11:      return 8'd30;
            default:                      return 8'd31;
        endcase
    endfunction

    function automatic logic [7:0] step(
        input logic [7:0] v,
        input logic [7:0] lo,
        input logic [7:0] hi,
        input logic       up
    );
        if (up) return (v >= hi) ? lo : v + 8'd1;
        return (v <= lo) ? hi : v - 8'd1;
    endfunction

    assign step_en    = btn_up ^ btn_down;
    assign editing    = (state_q != RUN) && (state_q != COMMIT);
    assign edit_field = editing ? state_q : 3'd0;
    assign set_time   = (state_q == COMMIT);
    assign bin_time   = {yr_q, mo_q, dy_q, hr_q, mi_q, se_q};

    assign mo_san  = (cur_month == 8'd0 || cur_month > 8'd12) ? 8'd1 : cur_month;
    assign mo_step = step(mo_q, 8'd1, 8'd12, btn_up);
    assign accept  = editing && (btn_cancel || btn_mode || step_en);

`ifdef WATCH_SET_TIMEOUT_EN
    logic [7:0] idle_q, idle_d;
`else
    logic unused_tick;
    assign unused_tick = clk1sec ^ (TIMEOUT_SEC == 0);
`endif

    always_comb begin
        state_d = state_q;
        yr_d    = yr_q;
        mo_d    = mo_q;
        dy_d    = dy_q;
        hr_d    = hr_q;
        mi_d    = mi_q;
        se_d    = se_q;
        case (state_q)
            RUN: begin
                if (btn_mode) begin
                    state_d = EDIT_YEAR;
                    yr_d    = cur_year;
                    mo_d    = mo_san;
                    if (cur_day == 8'd0)              dy_d = 8'd1;
                    else if (cur_day > max_day(mo_san)) dy_d = max_day(mo_san);
                    else                              dy_d = cur_day;
                    hr_d = (cur_hour   > 8'd23) ? 8'd0 : cur_hour;
                    mi_d = (cur_minute > 8'd59) ? 8'd0 : cur_minute;
                    se_d = (cur_second > 8'd59) ? 8'd0 : cur_second;
                end
            end
            COMMIT: state_d = RUN;
            default: begin
                if (btn_cancel) begin
                    state_d = RUN;
                end else if (btn_mode) begin
                    state_d = (state_q == EDIT_SEC) ? COMMIT
                                                    : state_e'(state_q + 3'd1);
                end else if (step_en) begin
                    unique case (1'b1)
                        state_q == EDIT_YEAR:  yr_d = step(yr_q, 8'd0, 8'd255, btn_up);
                        state_q == EDIT_MONTH: begin
                            mo_d = mo_step;
                            // keep the day legal for the new month
                            if (dy_q > max_day(mo_step)) dy_d = max_day(mo_step);
                        end
                        state_q == EDIT_DAY:   dy_d = step(dy_q, 8'd1, max_day(mo_q), btn_up);
                        state_q == EDIT_HOUR:  hr_d = step(hr_q, 8'd0, 8'd23, btn_up);
                        state_q == EDIT_MIN:   mi_d = step(mi_q, 8'd0, 8'd59, btn_up);
                        state_q == EDIT_SEC:   se_d = step(se_q, 8'd0, 8'd59, btn_up);
                        default: ;
                    endcase
                end
            end
        endcase
`ifdef WATCH_SET_TIMEOUT_EN
        idle_d = 8'd0;
        if (editing && !accept) begin
            idle_d = idle_q;
            if (clk1sec) begin
                if ({1'b0, idle_q} + 9'd1 >= 9'(TIMEOUT_SEC)) begin
                    state_d = RUN;
                    idle_d  = 8'd0;
                end else begin
                    idle_d = idle_q + 8'd1;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            yr_q    <= 8'd0;
            mo_q    <= 8'd0;
            dy_q    <= 8'd0;
            hr_q    <= 8'd0;
            mi_q    <= 8'd0;
            se_q    <= 8'd0;
`ifdef WATCH_SET_TIMEOUT_EN
            idle_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            yr_q    <= yr_d;
            mo_q    <= mo_d;
            dy_q    <= dy_d;
            hr_q    <= hr_d;
            mi_q    <= mi_d;
            se_q    <= se_d;
`ifdef WATCH_SET_TIMEOUT_EN
            idle_q  <= idle_d;
`endif
        end
    end

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Directed bench for watch_set_ctrl: edit flow, wrapping, clamping, cancel,
// sanitising, optional idle timeout and reset during COMMIT.
module tb_watch_set_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clk1sec = 1'b0;
    logic        btn_mode = 1'b0;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        btn_cancel = 1'b0;
    logic [7:0]  cur_year = 8'd0;
    logic [7:0]  cur_month = 8'd0;
    logic [7:0]  cur_day = 8'd0;
    logic [7:0]  cur_hour = 8'd0;
    logic [7:0]  cur_minute = 8'd0;
    logic [7:0]  cur_second = 8'd0;
    logic        set_time;
    logic [47:0] bin_time;
    logic        editing;
    logic [2:0]  edit_field;

    int total = 0;
    int bad = 0;
    int st_cnt = 0;
    int s0;

    always #5 clk = ~clk;

    always @(negedge clk) if (set_time) st_cnt++;

    watch_set_ctrl #(.TIMEOUT_SEC(3)) dut (
        .clk(clk), .rst(rst), .clk1sec(clk1sec),
        .btn_mode(btn_mode), .btn_up(btn_up),
        .btn_down(btn_down), .btn_cancel(btn_cancel),
        .cur_year(cur_year), .cur_month(cur_month), .cur_day(cur_day),
        .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_second(cur_second),
        .set_time(set_time), .bin_time(bin_time),
        .editing(editing), .edit_field(edit_field)
    );

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic m, input logic u, input logic d, input logic c);
        btn_mode = m; btn_up = u; btn_down = d; btn_cancel = c;
        tick();
        btn_mode = 0; btn_up = 0; btn_down = 0; btn_cancel = 0;
    endtask

    task automatic mode(); press(1, 0, 0, 0); endtask

    task automatic sec_pulse();
        clk1sec = 1'b1;
        tick();
        clk1sec = 1'b0;
        tick();
    endtask

    task automatic set_cur(input logic [47:0] v);
        {cur_year, cur_month, cur_day, cur_hour, cur_minute, cur_second} = v;
    endtask

    initial begin
        set_cur({8'd24, 8'd3, 8'd15, 8'd10, 8'd20, 8'd30});
        #12;
        chk("rst_bin", bin_time, 48'd0);
        chk("rst_edit", {45'd0, editing, set_time, 1'b0}, 48'd0);
        chk("rst_field", {45'd0, edit_field}, 48'd0);
        rst = 1'b1;
        tick();

        // enter edit mode
        mode();
        chk("enter_edit", {47'd0, editing}, 48'd1);
        chk("enter_field", {45'd0, edit_field}, 48'd1);
        chk("enter_bin", bin_time, {8'd24, 8'd3, 8'd15, 8'd10, 8'd20, 8'd30});
        press(0, 1, 0, 0);
        chk("year_up", bin_time, {8'd25, 8'd3, 8'd15, 8'd10, 8'd20, 8'd30});
        press(0, 0, 0, 1);
        chk("cancel_run", {47'd0, editing}, 48'd0);

        // wrap and clamp walk
        set_cur({8'd255, 8'd1, 8'd31, 8'd0, 8'd20, 8'd59});
        mode();
        chk("load2", bin_time, {8'd255, 8'd1, 8'd31, 8'd0, 8'd20, 8'd59});
        press(0, 1, 0, 0);
        chk("year_wrap", bin_time, {8'd0, 8'd1, 8'd31, 8'd0, 8'd20, 8'd59});
        mode();
        chk("field_month", {45'd0, edit_field}, 48'd2);
        press(0, 1, 0, 0);
        chk("month_clamp", bin_time, {8'd0, 8'd2, 8'd28, 8'd0, 8'd20, 8'd59});
        mode();
        mode();
        chk("field_hour", {45'd0, edit_field}, 48'd4);
        press(0, 0, 1, 0);
        chk("hour_wrap", bin_time, {8'd0, 8'd2, 8'd28, 8'd23, 8'd20, 8'd59});
        mode();
        mode();
        chk("field_sec", {45'd0, edit_field}, 48'd6);
        press(0, 1, 0, 0);
        chk("sec_wrap", bin_time, {8'd0, 8'd2, 8'd28, 8'd23, 8'd20, 8'd0});
        press(0, 1, 1, 0);
        chk("updown_ign", bin_time, {8'd0, 8'd2, 8'd28, 8'd23, 8'd20, 8'd0});
        s0 = st_cnt;
        mode();
        chk("commit_st", {47'd0, set_time}, 48'd1);
        chk("commit_fld", {45'd0, edit_field}, 48'd0);
        chk("commit_bin", bin_time, {8'd0, 8'd2, 8'd28, 8'd23, 8'd20, 8'd0});
        tick();
        chk("after_st", {46'd0, set_time, editing}, 48'd0);
        chk("st_width", 48'(st_cnt - s0), 48'd1);

        // cancel beats mode in EDIT_DAY
        set_cur({8'd24, 8'd3, 8'd15, 8'd10, 8'd20, 8'd30});
        mode();
        mode();
        mode();
        chk("field_day", {45'd0, edit_field}, 48'd3);
        s0 = st_cnt;
        press(1, 0, 0, 1);
        chk("cxl_mode", {44'd0, editing, edit_field}, 48'd0);
        tick();
        chk("cxl_nost", 48'(st_cnt - s0), 48'd0);
        chk("cxl_bin", bin_time, {8'd24, 8'd3, 8'd15, 8'd10, 8'd20, 8'd30});

        // sanitising on capture
        set_cur({8'd24, 8'd13, 8'd0, 8'd24, 8'd60, 8'd99});
        mode();
        chk("san_bad", bin_time, {8'd24, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0});
        press(0, 0, 0, 1);
        set_cur({8'd24, 8'd4, 8'd31, 8'd23, 8'd59, 8'd59});
        mode();
        chk("san_day", bin_time, {8'd24, 8'd4, 8'd30, 8'd23, 8'd59, 8'd59});
        press(0, 0, 1, 0);
        chk("year_dn", bin_time, {8'd23, 8'd4, 8'd30, 8'd23, 8'd59, 8'd59});
        press(0, 0, 0, 1);

        // idle in EDIT_MIN
        mode();
        repeat (4) mode();
        chk("field_min", {45'd0, edit_field}, 48'd5);
        s0 = st_cnt;
        sec_pulse();
        sec_pulse();
        chk("idle2_edit", {47'd0, editing}, 48'd1);
        sec_pulse();
`ifdef WATCH_SET_TIMEOUT_EN
        chk("timeout_run", {44'd0, editing, edit_field}, 48'd0);
`else
        chk("no_timeout", {44'd0, editing, edit_field}, 48'hD);
        press(0, 0, 0, 1);
`endif
        chk("timeout_nost", 48'(st_cnt - s0), 48'd0);

        // reset while in COMMIT
        mode();
        repeat (6) mode();
        chk("commit2_st", {47'd0, set_time}, 48'd1);
        s0 = st_cnt;
        rst = 1'b0;
        #1;
        chk("rst_commit", {45'd0, set_time, editing, 1'b0}, 48'd0);
        chk("rst_bin2", bin_time, 48'd0);
        #2;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_nost", 48'(st_cnt - s0), 48'd0);
        chk("rst_state", {44'd0, editing, edit_field}, 48'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
